// File: rtl/led_scan_mux_if.sv
// Pin bundle for led_scan_mux: capture/control inputs and display drives.
// master = datapath/bench side, slave = driver side.
interface led_scan_mux_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic                  blank_lz;
  logic                  a, b, c, d, e, f, g;
  logic                  dp_seg;
  logic [DIGITS-1:0]     digit;
  logic                  frame;

  modport master (
    output enable, load, value, dp, blank_lz,
    input  a, b, c, d, e, f, g, dp_seg, digit, frame
  );

  modport slave (
    input  enable, load, value, dp, blank_lz,
    output a, b, c, d, e, f, g, dp_seg, digit, frame
  );
endinterface

// File: rtl/led_scan_mux.sv
// Multiplexed DIGITS-wide hex 7-segment driver with blank slot, LZ blanking.
// Ports: clk, reset (sync, active-high), io (led_scan_mux_if.slave).
module led_scan_mux #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input logic           clk,
  input logic           reset,
  led_scan_mux_if.slave io
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] sh_val;
  logic [DIGITS-1:0]   sh_dp;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                wrap_q;

  logic                slot_end;
  logic                scan_end;
  logic [3:0]          nib;
  logic                dp_cur;
  logic                hi_nz;
  logic                suppress;
  logic [6:0]          hex;

  logic [6:0]          seg_n, seg_q;
  logic                dp_n, dp_q;
  logic [DIGITS-1:0]   dig_n, dig_q;
  logic                frame_n, frame_q;

  assign slot_end = (cnt == CW'(PRESCALE - 1));
  assign scan_end = slot_end && (idx == IW'(DIGITS - 1));

  // Scan state: wrap_q remembers that the last enabled edge
  // closed a full scan, so frame lines up with the lagged pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_val <= '0;
      sh_dp  <= '0;
      cnt    <= '0;
      idx    <= '0;
      wrap_q <= 1'b0;
    end else begin
      if (io.load) begin
        sh_val <= io.value;
        sh_dp  <= io.dp;
      end
      if (io.enable) begin
        wrap_q <= scan_end;
        if (slot_end) begin
          cnt <= '0;
          if (idx == IW'(DIGITS - 1))
            idx <= '0;
          else
            idx <= idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Current nibble, its dp, and whether any nibble at or above
  // the current index is nonzero (for leading-zero blanking).
  always_comb begin
    nib    = '0;
    dp_cur = 1'b0;
    hi_nz  = 1'b0;
    dig_n  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) begin
        nib      = sh_val[4*i +: 4];
        dp_cur   = sh_dp[i];
        dig_n[i] = io.enable && (cnt != '0);
      end
      if ((IW'(i) >= idx) && (sh_val[4*i +: 4] != 4'h0))
        hi_nz = 1'b1;
    end
  end

  // {a,b,c,d,e,f,g}
  always_comb begin
    hex = '0;
    unique case (nib)
      4'h0: hex = 7'h7E;
      4'h1: hex = 7'h30;
      4'h2: hex = 7'h6D;
      4'h3: hex = 7'h79;
      4'h4: hex = 7'h33;
      4'h5: hex = 7'h5B;
      4'h6: hex = 7'h5F;
      4'h7: hex = 7'h70;
      4'h8: hex = 7'h7F;
      4'h9: hex = 7'h7B;
      4'hA: hex = 7'h77;
      4'hB: hex = 7'h1F;
      4'hC: hex = 7'h4E;
      4'hD: hex = 7'h3D;
      4'hE: hex = 7'h4F;
      4'hF: hex = 7'h47;
    endcase
  end

  assign suppress = io.blank_lz && (idx != '0) && !hi_nz;
  assign seg_n    = (io.enable && !suppress) ? hex : 7'h00;
  assign dp_n     = io.enable && dp_cur;
  assign frame_n  = io.enable && wrap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q   <= '0;
      dp_q    <= 1'b0;
      dig_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_n;
      dp_q    <= dp_n;
      dig_q   <= dig_n;
      frame_q <= frame_n;
    end
  end

  // Registers hold logical "on"; polarity is applied at the pins.
  assign io.a      = seg_q[6] ^ SEG_ACTIVE_LOW;
  assign io.b      = seg_q[5] ^ SEG_ACTIVE_LOW;
  assign io.c      = seg_q[4] ^ SEG_ACTIVE_LOW;
  assign io.d      = seg_q[3] ^ SEG_ACTIVE_LOW;
  assign io.e      = seg_q[2] ^ SEG_ACTIVE_LOW;
  assign io.f      = seg_q[1] ^ SEG_ACTIVE_LOW;
  assign io.g      = seg_q[0] ^ SEG_ACTIVE_LOW;
  assign io.dp_seg = dp_q ^ SEG_ACTIVE_LOW;
  assign io.digit  = dig_q ^ {DIGITS{DIG_ACTIVE_LOW}};
  assign io.frame  = frame_q;
endmodule

// File: tb/tb_led_scan_mux.sv
// Bench for led_scan_mux: three instances (plain, inverted pins, 1-digit).
// Vectors, hand sequences and random stimulus against a slot-time model.
module tb_led_scan_mux;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_scan_mux_if #(.DIGITS(4)) if0 ();
  led_scan_mux_if #(.DIGITS(4)) if1 ();
  led_scan_mux_if #(.DIGITS(1)) if2 ();

  led_scan_mux #(.DIGITS(4), .PRESCALE(4)) u0 (
    .clk(clk), .reset(reset), .io(if0)
  );
  led_scan_mux #(
    .DIGITS(4), .PRESCALE(4),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u1 (
    .clk(clk), .reset(reset), .io(if1)
  );
  led_scan_mux #(.DIGITS(1), .PRESCALE(2)) u2 (
    .clk(clk), .reset(reset), .io(if2)
  );

  int checks = 0;
  int errors = 0;

  string hex_segs [16] = '{
    "abcdef", "bc", "abdeg", "abcdg",
    "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg",
    "adef", "bcdeg", "adefg", "aefg"
  };

  // pos = number of enabled edges since reset; slot time is derived from it
  typedef struct {
    logic [31:0] sh_val;
    logic [7:0]  sh_dp;
    int          pos;
  } mdl_t;

  mdl_t m0, m2;

  // out vector layout: {seg a..g, dp, digit[7:0], frame}
  typedef logic [16:0] ovec_t;

  function automatic logic [6:0] seg_of(int n);
    logic [6:0] r = '0;
    string s = hex_segs[n];
    for (int i = 0; i < s.len(); i++)
      r[6 - (int'(s.getc(i)) - 97)] = 1'b1;
    return r;
  endfunction

  function automatic ovec_t mexp(mdl_t m, int nd, int ps,
                                 logic en, logic bz);
    int idx = (m.pos / ps) % nd;
    int cnt = m.pos % ps;
    int nib = int'((m.sh_val >> (4 * idx)) & 32'hF);
    logic sup = bz && (idx > 0) && ((m.sh_val >> (4 * idx)) == 0);
    logic [6:0] s = (en && !sup) ? seg_of(nib) : 7'h00;
    logic [7:0] dg = '0;
    logic fr = en && (m.pos > 0) && (m.pos % (ps * nd) == 0);
    if (en && cnt != 0) dg[idx] = 1'b1;
    return {s, en & m.sh_dp[idx], dg, fr};
  endfunction

  function automatic mdl_t mnext(mdl_t m, logic r, logic en, logic ld,
                                 logic [31:0] v, logic [7:0] d);
    mdl_t n = m;
    if (r) begin
      n.sh_val = '0;
      n.sh_dp  = '0;
      n.pos    = 0;
    end else begin
      if (ld) begin
        n.sh_val = v;
        n.sh_dp  = d;
      end
      if (en) n.pos = m.pos + 1;
    end
    return n;
  endfunction

  function automatic ovec_t act0();
    return {if0.a, if0.b, if0.c, if0.d, if0.e, if0.f, if0.g,
            if0.dp_seg, 4'b0, if0.digit, if0.frame};
  endfunction

  function automatic ovec_t act1();
    return {if1.a, if1.b, if1.c, if1.d, if1.e, if1.f, if1.g,
            if1.dp_seg, 4'b0, if1.digit, if1.frame};
  endfunction

  function automatic ovec_t act2();
    return {if2.a, if2.b, if2.c, if2.d, if2.e, if2.f, if2.g,
            if2.dp_seg, 7'b0, if2.digit, if2.frame};
  endfunction

  task automatic chk(string nm, ovec_t act, ovec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  logic        c_r, c_e, c_l, c_bz;
  logic [15:0] c_v;
  logic [3:0]  c_d;

  // Drive inputs, clock once, compare all three DUTs to the model.
  task automatic step(logic r, logic en, logic ld,
                      logic [15:0] v, logic [3:0] d, logic bz);
    ovec_t e0, e1, e2;
    c_r = r; c_e = en; c_l = ld; c_v = v; c_d = d; c_bz = bz;
    reset = r;
    if0.enable = en; if0.load = ld; if0.value = v;
    if0.dp = d; if0.blank_lz = bz;
    if1.enable = en; if1.load = ld; if1.value = v;
    if1.dp = d; if1.blank_lz = bz;
    if2.enable = en; if2.load = ld; if2.value = v[3:0];
    if2.dp = d[0]; if2.blank_lz = bz;
    e0 = r ? '0 : mexp(m0, 4, 4, en, bz);
    e2 = r ? '0 : mexp(m2, 1, 2, en, bz);
    e1 = e0 ^ {7'h7F, 1'b1, 8'h0F, 1'b0};
    @(posedge clk);
    #1;
    chk("u0_pins", act0(), e0);
    chk("u1_pins", act1(), e1);
    chk("u2_pins", act2(), e2);
    m0 = mnext(m0, r, en, ld, {16'h0, v}, {4'h0, d});
    m2 = mnext(m2, r, en, ld, {28'h0, v[3:0]}, {7'h0, d[0]});
  endtask

  task automatic hold();
    step(1'b0, c_e, 1'b0, c_v, c_d, c_bz);
  endtask

  // Advance until the edge that shows slot s lit (pre-edge count 1).
  task automatic goto_slot(int s);
    int n = 0;
    while (!((m0.pos % 4 == 1) && ((m0.pos / 4) % 4 == s)) && n < 40) begin
      hold();
      n++;
    end
    hold();
  endtask

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blz;
    int          slot;
    logic [6:0]  seg;
    logic        dps;
  } vec_t;

  vec_t vt [14];

  initial begin
    int fr;
    vt[0]  = '{16'h12AF, 4'b0100, 1'b0, 0, 7'h47, 1'b0};
    vt[1]  = '{16'h12AF, 4'b0100, 1'b0, 1, 7'h77, 1'b0};
    vt[2]  = '{16'h12AF, 4'b0100, 1'b0, 2, 7'h6D, 1'b1};
    vt[3]  = '{16'h12AF, 4'b0100, 1'b0, 3, 7'h30, 1'b0};
    vt[4]  = '{16'h0030, 4'b0000, 1'b1, 3, 7'h00, 1'b0};
    vt[5]  = '{16'h0030, 4'b0000, 1'b1, 2, 7'h00, 1'b0};
    vt[6]  = '{16'h0030, 4'b0000, 1'b1, 1, 7'h79, 1'b0};
    vt[7]  = '{16'h0030, 4'b0000, 1'b1, 0, 7'h7E, 1'b0};
    vt[8]  = '{16'h0030, 4'b0000, 1'b0, 3, 7'h7E, 1'b0};
    vt[9]  = '{16'h0000, 4'b0000, 1'b1, 0, 7'h7E, 1'b0};
    vt[10] = '{16'h0000, 4'b0000, 1'b1, 1, 7'h00, 1'b0};
    vt[11] = '{16'h0000, 4'b1000, 1'b1, 3, 7'h00, 1'b1};
    vt[12] = '{16'h0800, 4'b0000, 1'b1, 2, 7'h7F, 1'b0};
    vt[13] = '{16'h0800, 4'b0000, 1'b1, 3, 7'h00, 1'b0};

    m0 = '{default: '0};
    m2 = '{default: '0};

    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    chk("reset_u0", act0(), 17'h0);
    chk("reset_u1", act1(), {7'h7F, 1'b1, 8'h0F, 1'b0});

    // Shadow is zero after release: digit 0 shows "0".
    step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    goto_slot(0);
    chk("rst_shadow", {act0()[16:10], 10'h0}, {7'h7E, 10'h0});

    // Two full scans: exactly two frame pulses.
    step(1'b0, 1'b1, 1'b1, 16'h12AF, 4'b0100, 1'b0);
    fr = 0;
    for (int i = 0; i < 32; i++) begin
      hold();
      fr += int'(if0.frame);
    end
    chk("frame_cnt", 17'(fr), 17'd2);

    foreach (vt[i]) begin
      step(1'b0, 1'b1, 1'b1, vt[i].value, vt[i].dp, vt[i].blz);
      goto_slot(vt[i].slot);
      chk($sformatf("vec%0d", i),
          {act0()[16:9], 4'h0, act0()[4:1], 1'b0},
          {vt[i].seg, vt[i].dps, 4'h0, 4'(1 << vt[i].slot), 1'b0});
    end

    // Enable drop at count 2 with a load; resume later.
    step(1'b0, 1'b1, 1'b1, 16'h4321, 4'h0, 1'b0);
    while (m0.pos % 4 != 2) hold();
    step(1'b0, 1'b0, 1'b1, 16'h8888, 4'hF, 1'b0);
    chk("en_drop", act0(), 17'h0);
    chk("en_drop_inv", act1(), {7'h7F, 1'b1, 8'h0F, 1'b0});
    for (int i = 0; i < 3; i++) hold();
    step(1'b0, 1'b1, 1'b0, 16'h8888, 4'hF, 1'b0);
    for (int i = 0; i < 6; i++) hold();
    goto_slot(2);
    chk("pol_8", {act1()[16:10], 1'b0, act1()[8:1], 1'b0},
        {7'h00, 1'b0, 8'h0B, 1'b0});

    // Reset with load at the same edge, mid-scan.
    for (int i = 0; i < 5; i++) hold();
    step(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b0);
    chk("rst_ld_u0", act0(), 17'h0);
    chk("rst_ld_u2", act2(), 17'h0);
    fr = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
      fr += int'(if2.frame);
    end
    chk("u2_frames", 17'(fr), 17'd4);
    goto_slot(0);
    chk("rst_ld_shadow", {act0()[16:9], 9'h0}, {7'h7E, 1'b0, 9'h0});

    // Random traffic; nibbles zero half the time to exercise LZ blanking.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      for (int k = 0; k < 4; k++)
        v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 7) == 0, v, 4'($urandom),
           1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
